// File: rtl/tinker_dual_port_memory_if.sv
// Request/response bundle for the dual-port memory: instruction-fetch port and data port.
interface tinker_dual_port_memory_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 64
);
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_data;
  logic              busy;

  modport master (
    output if_req_valid, if_addr, d_req_valid, d_req_we, d_addr, d_wdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    input  d_req_ready, d_rsp_valid, d_rsp_data, busy
  );

  modport slave (
    input  if_req_valid, if_addr, d_req_valid, d_req_we, d_addr, d_wdata,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    output d_req_ready, d_rsp_valid, d_rsp_data, busy
  );
endinterface

// File: rtl/tinker_dual_port_memory.sv
// Byte-addressed little-endian memory shared by a fetch port and a data port with fixed read latency.
// Define TINKER_MEM_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module tinker_dual_port_memory #(
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset,
  tinker_dual_port_memory_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0]        r_mem [0:DEPTH-1];
  logic              w_if_ready;
  logic              w_d_ready;
  logic              w_if_acc;
  logic              w_d_acc;
  logic              w_d_rd_acc;
  logic [31:0]       w_if_rd;
  logic [DATA_W-1:0] w_d_rd;
  logic [LATENCY-1:0] r_if_vld;
  logic [LATENCY-1:0] r_d_vld;
  logic [31:0]       r_if_dat [LATENCY];
  logic [DATA_W-1:0] r_d_dat  [LATENCY];

`ifdef TINKER_MEM_RR_EN
  // r_prio_d set means the data port wins the next contended cycle.
  logic r_prio_d;

  always_comb begin
    w_if_ready = reset && (!bus.d_req_valid || !r_prio_d);
    w_d_ready  = reset && (!bus.if_req_valid || r_prio_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prio_d <= 1'b0;
    end else if (w_if_acc) begin
      r_prio_d <= 1'b1;
    end else if (w_d_acc) begin
      r_prio_d <= 1'b0;
    end
  end
`else
  assign w_if_ready = reset && !bus.d_req_valid;
  assign w_d_ready  = reset;
`endif

  assign w_if_acc   = bus.if_req_valid && w_if_ready;
  assign w_d_acc    = bus.d_req_valid && w_d_ready;
  assign w_d_rd_acc = w_d_acc && !bus.d_req_we;

  assign bus.if_req_ready = w_if_ready;
  assign bus.d_req_ready  = w_d_ready;

  // Byte lanes: address arithmetic is ADDR_W wide, so accesses wrap at the top of the array.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_if_lane
      assign w_if_rd[8*gi +: 8] = r_mem[bus.if_addr + ADDR_W'(gi)];
    end
    for (gi = 0; gi < NB; gi++) begin : g_d_lane
      assign w_d_rd[8*gi +: 8] = r_mem[bus.d_addr + ADDR_W'(gi)];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_d_acc && bus.d_req_we) begin
      for (int b = 0; b < NB; b++) begin
        r_mem[bus.d_addr + ADDR_W'(b)] <= bus.d_wdata[8*b +: 8];
      end
    end
  end

  // Data stages only load behind a valid stage so the output holds its last response.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_if_vld <= '0;
      r_d_vld  <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        r_if_dat[s] <= '0;
        r_d_dat[s]  <= '0;
      end
    end else begin
      r_if_vld[0] <= w_if_acc;
      r_d_vld[0]  <= w_d_rd_acc;
      if (w_if_acc) begin
        r_if_dat[0] <= w_if_rd;
      end
      if (w_d_rd_acc) begin
        r_d_dat[0] <= w_d_rd;
      end
      for (int s = 1; s < LATENCY; s++) begin
        r_if_vld[s] <= r_if_vld[s-1];
        r_d_vld[s]  <= r_d_vld[s-1];
        if (r_if_vld[s-1]) begin
          r_if_dat[s] <= r_if_dat[s-1];
        end
        if (r_d_vld[s-1]) begin
          r_d_dat[s] <= r_d_dat[s-1];
        end
      end
    end
  end

  assign bus.if_rsp_valid = r_if_vld[LATENCY-1];
  assign bus.if_rsp_data  = r_if_dat[LATENCY-1];
  assign bus.d_rsp_valid  = r_d_vld[LATENCY-1];
  assign bus.d_rsp_data   = r_d_dat[LATENCY-1];
  assign bus.busy         = (|r_if_vld) || (|r_d_vld);
endmodule

// File: tb/tb_tinker_dual_port_memory.sv
// Scoreboard bench for tinker_dual_port_memory: byte-array reference model, queued expectations,
// independent response monitor. Honours TINKER_MEM_RR_EN for the arbitration model.
module tb_tinker_dual_port_memory;
  localparam int AW  = 19;
  localparam int DW  = 64;
  localparam int LAT = 2;
  localparam int NB  = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t if_q[$];
  exp_t d_q[$];
  logic [7:0] mdl [0:DEPTH-1];
  logic tb_prio_d = 1'b0;

  tinker_dual_port_memory_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  tinker_dual_port_memory #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mrd(input logic [AW-1:0] a, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[a + AW'(i)];
    return v;
  endfunction

  function automatic void mwr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    for (int i = 0; i < NB; i++) mdl[a + AW'(i)] = d[8*i +: 8];
  endfunction

  // One bus cycle: called just after a rising edge, returns just after the next one.
  task automatic step(input logic iv, input logic [AW-1:0] ia, input logic dv, input logic dwe,
                      input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                      output logic if_acc, output logic d_acc);
    logic exp_ifr, exp_dr;
    exp_t e;
    bus.if_req_valid = iv;
    bus.if_addr      = ia;
    bus.d_req_valid  = dv;
    bus.d_req_we     = dwe;
    bus.d_addr       = da;
    bus.d_wdata      = dwd;
    @(negedge clk);
    if (!reset) begin
      exp_ifr = 1'b0;
      exp_dr  = 1'b0;
      chk("if_ready_in_reset", bus.if_req_ready, 0);
      chk("d_ready_in_reset", bus.d_req_ready, 0);
    end else begin
`ifdef TINKER_MEM_RR_EN
      exp_ifr = !(iv && dv) || !tb_prio_d;
      exp_dr  = !(iv && dv) || tb_prio_d;
      if (iv) chk("if_ready", bus.if_req_ready, exp_ifr);
      if (dv) chk("d_ready", bus.d_req_ready, exp_dr);
`else
      exp_dr  = 1'b1;
      exp_ifr = !dv;
      chk("if_ready", bus.if_req_ready, exp_ifr);
      chk("d_ready", bus.d_req_ready, exp_dr);
`endif
    end
    if_acc = iv && exp_ifr;
    d_acc  = dv && exp_dr;
    if (if_acc) begin
      e.due  = cyc + LAT;
      e.data = mrd(ia, 4);
      if_q.push_back(e);
      tb_prio_d = 1'b1;
    end
    if (d_acc) begin
      if (dwe) begin
        mwr(da, dwd);
        $display("d_store  cycle %0d addr %h data %h", cyc, da, dwd);
      end else begin
        e.due  = cyc + LAT;
        e.data = mrd(da, NB);
        d_q.push_back(e);
      end
      tb_prio_d = 1'b0;
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      if_q.delete();
      d_q.delete();
      tb_prio_d = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    logic a1, a2;
    repeat (n) step(1'b0, '0, 1'b0, 1'b0, '0, '0, a1, a2);
  endtask

  task automatic req_if(input logic [AW-1:0] a);
    logic a1, a2;
    int n = 0;
    do begin
      step(1'b1, a, 1'b0, 1'b0, '0, '0, a1, a2);
      n++;
    end while (!a1 && n < 8);
    if (!a1) chk("if_accept_timeout", 0, 1);
  endtask

  task automatic req_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic a1, a2;
    int n = 0;
    do begin
      step(1'b0, '0, 1'b1, we, a, d, a1, a2);
      n++;
    end while (!a2 && n < 8);
    if (!a2) chk("d_accept_timeout", 0, 1);
  endtask

  // Monitor: busy against outstanding model reads, responses against queued expectations.
  initial forever begin
    logic busy_exp;
    exp_t e;
    @(negedge clk);
    busy_exp = 1'b0;
    foreach (if_q[i]) if (if_q[i].due - LAT + 1 <= cyc) busy_exp = 1'b1;
    foreach (d_q[i])  if (d_q[i].due - LAT + 1 <= cyc) busy_exp = 1'b1;
    chk("busy", bus.busy, busy_exp);

    if (bus.if_rsp_valid) begin
      if (if_q.size() == 0) begin
        chk("if_rsp_unexpected_valid", 1, 0);
      end else begin
        e = if_q.pop_front();
        $display("if_rsp   cycle %0d data %h expected %h", cyc, bus.if_rsp_data, e.data[31:0]);
        chk("if_rsp_cycle", cyc, e.due);
        chk("if_rsp_data", bus.if_rsp_data, e.data[31:0]);
      end
    end else if (if_q.size() > 0 && if_q[0].due <= cyc) begin
      e = if_q.pop_front();
      chk("if_rsp_missing_valid", 0, 1);
    end

    if (bus.d_rsp_valid) begin
      if (d_q.size() == 0) begin
        chk("d_rsp_unexpected_valid", 1, 0);
      end else begin
        e = d_q.pop_front();
        $display("d_rsp    cycle %0d data %h expected %h", cyc, bus.d_rsp_data, e.data);
        chk("d_rsp_cycle", cyc, e.due);
        chk("d_rsp_data", bus.d_rsp_data, e.data);
      end
    end else if (d_q.size() > 0 && d_q[0].due <= cyc) begin
      e = d_q.pop_front();
      chk("d_rsp_missing_valid", 0, 1);
    end
  end

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(3))
      0: return AW'(32'h100 + $urandom_range(15));
      1: return AW'(DEPTH - 8 + $urandom_range(7));
      2: return AW'(32'h2000 + $urandom_range(7));
      default: return AW'($urandom);
    endcase
  endfunction

  initial begin
    logic a1, a2;
    logic ip, dp, dwe;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dwd;
    int k;

    reset = 1'b0;
    bus.if_req_valid = 1'b0;
    bus.if_addr      = '0;
    bus.d_req_valid  = 1'b0;
    bus.d_req_we     = 1'b0;
    bus.d_addr       = '0;
    bus.d_wdata      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = 8'(i * 37 + (i >> 8));
      dut.r_mem[i] = mdl[i];
    end
    mdl[32'h2000] = 8'h13; dut.r_mem[32'h2000] = 8'h13;
    mdl[32'h2001] = 8'h57; dut.r_mem[32'h2001] = 8'h57;
    mdl[32'h2002] = 8'h9B; dut.r_mem[32'h2002] = 8'h9B;
    mdl[32'h2003] = 8'hDF; dut.r_mem[32'h2003] = 8'hDF;

    idle(3);
    chk("if_rsp_data_reset", bus.if_rsp_data, 0);
    chk("d_rsp_data_reset", bus.d_rsp_data, 0);
    reset = 1'b1;
    idle(1);

    // Reads in flight across a 2-cycle reset; a store presented during reset must not land.
    step(1'b1, AW'(32'h2000), 1'b1, 1'b0, AW'(32'h108), '0, a1, a2);
    step(1'b1, AW'(32'h2000), 1'b0, 1'b0, '0, '0, a1, a2);
    reset = 1'b0;
    step(1'b0, '0, 1'b1, 1'b1, AW'(32'h300), 64'hDEAD_BEEF_0BAD_F00D, a1, a2);
    step(1'b0, '0, 1'b1, 1'b1, AW'(32'h300), 64'hDEAD_BEEF_0BAD_F00D, a1, a2);
    reset = 1'b1;
    idle(LAT + 2);
    req_d(1'b0, AW'(32'h300), '0);
    idle(LAT + 1);

    // Little-endian fetch of preloaded bytes.
    req_if(AW'(32'h2000));
    idle(LAT + 1);

    // Store then load on the very next cycle.
    req_d(1'b1, AW'(32'h100), 64'h1122_3344_5566_7788);
    req_d(1'b0, AW'(32'h100), '0);
    idle(LAT + 1);
    chk("mem_byte_0x100", dut.r_mem[32'h100], 8'h88);

    // Wrapping store at the top of the array.
    req_d(1'b1, AW'(32'h7FFFC), 64'h1122_3344_5566_7788);
    req_d(1'b0, AW'(32'h7FFFC), '0);
    req_if(AW'(32'h0));
    idle(LAT + 1);
    chk("mem_byte_0x7FFFC", dut.r_mem[32'h7FFFC], 8'h88);
    chk("mem_byte_0x3", dut.r_mem[32'h3], 8'h11);

    // Both ports contending for four cycles.
    ia = AW'(32'h2000);
    da = AW'(32'h100);
    for (k = 0; k < 4; k++) begin
      step(1'b1, ia, 1'b1, 1'b0, da, '0, a1, a2);
      $display("contend  cycle %0d grant_if %0d grant_d %0d", cyc, a1, a2);
      if (a1) ia = ia + AW'(4);
      if (a2) da = da + AW'(8);
    end
    req_if(ia);
    idle(LAT + 1);

    // Three back-to-back fetches.
    step(1'b1, AW'(32'h2000), 1'b0, 1'b0, '0, '0, a1, a2);
    step(1'b1, AW'(32'h2004), 1'b0, 1'b0, '0, '0, a1, a2);
    step(1'b1, AW'(32'h7FFFE), 1'b0, 1'b0, '0, '0, a1, a2);
    idle(LAT + 1);

    // Randomized traffic; unaccepted requests are held stable.
    ip = 1'b0; dp = 1'b0; dwe = 1'b0; dwd = '0;
    for (k = 0; k < 400; k++) begin
      if (!ip && $urandom_range(2) != 0) begin
        ip = 1'b1;
        ia = pick_addr();
      end
      if (!dp && $urandom_range(2) != 0) begin
        dp  = 1'b1;
        dwe = 1'($urandom_range(1));
        da  = pick_addr();
        dwd = {$urandom, $urandom};
      end
      step(ip, ia, dp, dwe, da, dwd, a1, a2);
      if (a1) ip = 1'b0;
      if (a2) dp = 1'b0;
    end

    idle(LAT + 3);
    chk("if_outstanding_at_end", if_q.size(), 0);
    chk("d_outstanding_at_end", d_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
